// File: rtl/versatile_mem_ctrl_ddr_wr_seq_if.sv
// Sequencer-side bundle: write command, show-ahead Tx FIFO read port, PHY drive and status.
interface versatile_mem_ctrl_ddr_wr_seq_if;
  logic        wr_start;
  logic [31:0] fifo_dat;
  logic [3:0]  fifo_be;
  logic        fifo_empty;
  logic        fifo_rd;
  logic [35:0] tx_dat;
  logic        dq_en;
  logic        dqm_en;
  logic        busy;
  logic        done;
  logic        underrun;
  logic        start_err;
  logic [15:0] burst_cnt;

  modport master (
    output wr_start, fifo_dat, fifo_be, fifo_empty,
    input  fifo_rd, tx_dat, dq_en, dqm_en, busy, done, underrun, start_err, burst_cnt
  );

  modport slave (
    input  wr_start, fifo_dat, fifo_be, fifo_empty,
    output fifo_rd, tx_dat, dq_en, dqm_en, busy, done, underrun, start_err, burst_cnt
  );
endinterface

// File: rtl/versatile_mem_ctrl_ddr_wr_seq.sv
// DDR2 write-data sequencer: WL wait, preamble, BL packed words, postamble on clk_270.
// Optional completed-burst counter enabled by defining DDR_WR_SEQ_BURST_CNT_EN.
module versatile_mem_ctrl_ddr_wr_seq #(
  parameter int BL = 4,
  parameter int WL = 2
) (
  input logic                           clk_270,
  input logic                           wb_rst,
  versatile_mem_ctrl_ddr_wr_seq_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_PRE, S_BURST, S_POST} state_t;

  localparam logic [3:0] WL_LOAD   = 4'(WL - 1);
  localparam logic [3:0] WORD_LAST = 4'(BL - 1);
  // Outputs are registered from the state being left, so WL=1 must go straight to PRE.
  localparam state_t     START_TO  = (WL == 1) ? S_PRE : S_WAIT;

  state_t      state;
  logic [3:0]  wl_cnt;
  logic [3:0]  wcnt;
  logic [35:0] tx_dat;
  logic        dq_en;
  logic        dqm_en;
  logic        done;
  logic        underrun;
  logic        start_err;
  logic        fifo_rd;

  assign fifo_rd       = (state == S_BURST) && !bus.fifo_empty;
  assign bus.fifo_rd   = fifo_rd;
  assign bus.tx_dat    = tx_dat;
  assign bus.dq_en     = dq_en;
  assign bus.dqm_en    = dqm_en;
  assign bus.done      = done;
  assign bus.busy      = (state != S_IDLE);
  assign bus.underrun  = underrun;
  assign bus.start_err = start_err;

  always_ff @(posedge clk_270 or posedge wb_rst) begin
    if (wb_rst) begin
      state     <= S_IDLE;
      wl_cnt    <= '0;
      wcnt      <= '0;
      tx_dat    <= '0;
      dq_en     <= 1'b0;
      dqm_en    <= 1'b0;
      done      <= 1'b0;
      underrun  <= 1'b0;
      start_err <= 1'b0;
    end else begin
      tx_dat <= '0;
      dq_en  <= 1'b0;
      dqm_en <= 1'b0;
      done   <= 1'b0;
      if (bus.wr_start && (state == S_WAIT || state == S_PRE || state == S_BURST))
        start_err <= 1'b1;
      case (state)
        S_IDLE: begin
          if (bus.wr_start) begin
            state    <= START_TO;
            wl_cnt   <= WL_LOAD;
            underrun <= 1'b0;
          end
        end
        S_WAIT: begin
          wl_cnt <= wl_cnt - 4'd1;
          if (wl_cnt == 4'd1) state <= S_PRE;
        end
        S_PRE: begin
          dq_en  <= 1'b1;
          dqm_en <= 1'b1;
          wcnt   <= '0;
          state  <= S_BURST;
        end
        S_BURST: begin
          dq_en <= 1'b1;
          // An empty FIFO still burns the word slot; the memory burst length is fixed.
          if (fifo_rd) begin
            tx_dat <= {bus.fifo_dat, bus.fifo_be};
          end else begin
            dqm_en   <= 1'b1;
            underrun <= 1'b1;
          end
          wcnt <= wcnt + 4'd1;
          if (wcnt == WORD_LAST) state <= S_POST;
        end
        S_POST: begin
          dq_en  <= 1'b1;
          dqm_en <= 1'b1;
          done   <= 1'b1;
          if (bus.wr_start) begin
            state  <= START_TO;
            wl_cnt <= WL_LOAD;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DDR_WR_SEQ_BURST_CNT_EN
  logic [15:0] burst_cnt;

  always_ff @(posedge clk_270 or posedge wb_rst) begin
    if (wb_rst)                burst_cnt <= '0;
    else if (state == S_POST)  burst_cnt <= burst_cnt + 16'd1;
  end

  assign bus.burst_cnt = burst_cnt;
`else
  assign bus.burst_cnt = 16'h0;
`endif
endmodule

// File: tb/tb_versatile_mem_ctrl_ddr_wr_seq.sv
// Directed + random bench for the DDR write sequencer against a burst-window reference model.
module tb_versatile_mem_ctrl_ddr_wr_seq;
  localparam int BL = 4;
  localparam int WL = 2;

  logic clk_270 = 1'b0;
  logic wb_rst  = 1'b1;

  versatile_mem_ctrl_ddr_wr_seq_if bus();

  versatile_mem_ctrl_ddr_wr_seq #(.BL(BL), .WL(WL)) dut (
    .clk_270 (clk_270),
    .wb_rst  (wb_rst),
    .bus     (bus)
  );

  always #5 clk_270 = ~clk_270;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int a      = -100;  // edge at which the most recent burst was accepted
  int bcnt   = 0;
  logic und_m  = 1'b0;
  logic serr_m = 1'b0;
  logic [35:0] fifo_q[$];
  logic [35:0] mdl_q[$];

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  task automatic drive_fifo();
    bus.fifo_empty = (fifo_q.size() == 0);
    if (fifo_q.size() > 0) {bus.fifo_dat, bus.fifo_be} = fifo_q[0];
    else                   {bus.fifo_dat, bus.fifo_be} = 36'h0;
  endtask

  task automatic push(input logic [35:0] w);
    fifo_q.push_back(w);
    mdl_q.push_back(w);
    drive_fifo();
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++) push({$urandom, 4'($urandom)});
  endtask

  function automatic logic [15:0] bcnt_req();
`ifdef DDR_WR_SEQ_BURST_CNT_EN
    return 16'(bcnt);
`else
    return 16'h0;
`endif
  endfunction

  task automatic step(input logic st);
    int o;
    logic rd_obs, rd_req;
    logic [35:0] tx_req;
    logic dq_req, dqm_req, done_req, busy_req;
    bus.wr_start = st;
    #1;
    o = cyc + 1 - a;
    rd_req = (o > WL) && (o <= WL + BL) && (mdl_q.size() > 0);
    rd_obs = bus.fifo_rd;
    chk("fifo_rd", 36'(rd_obs), 36'(rd_req));
    @(posedge clk_270);
    #1;
    cyc++;
    if (rd_obs && fifo_q.size() > 0) void'(fifo_q.pop_front());
    drive_fifo();
    // Expected PHY drive for this edge from the offset within the active burst window.
    o = cyc - a;
    tx_req = '0; dq_req = 0; dqm_req = 0; done_req = 0;
    if (o == WL) begin
      dq_req = 1; dqm_req = 1;
    end else if (o > WL && o <= WL + BL) begin
      dq_req = 1;
      if (mdl_q.size() > 0) tx_req = mdl_q.pop_front();
      else begin dqm_req = 1; und_m = 1; end
    end else if (o == WL + BL + 1) begin
      dq_req = 1; dqm_req = 1; done_req = 1; bcnt++;
    end
    if (st) begin
      if (cyc >= a + WL + BL + 1) begin
        if (cyc > a + WL + BL + 1) und_m = 0;
        a = cyc;
      end else begin
        serr_m = 1;
      end
    end
    busy_req = (cyc >= a) && (cyc < a + WL + BL + 1);
    chk("tx_dat",    bus.tx_dat,          tx_req);
    chk("dq_en",     36'(bus.dq_en),      36'(dq_req));
    chk("dqm_en",    36'(bus.dqm_en),     36'(dqm_req));
    chk("done",      36'(bus.done),       36'(done_req));
    chk("busy",      36'(bus.busy),       36'(busy_req));
    chk("underrun",  36'(bus.underrun),   36'(und_m));
    chk("start_err", 36'(bus.start_err),  36'(serr_m));
    chk("burst_cnt", 36'(bus.burst_cnt),  36'(bcnt_req()));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tx_dat"},    bus.tx_dat,         36'h0);
    chk({tag, "_dq_en"},     36'(bus.dq_en),     36'h0);
    chk({tag, "_dqm_en"},    36'(bus.dqm_en),    36'h0);
    chk({tag, "_done"},      36'(bus.done),      36'h0);
    chk({tag, "_busy"},      36'(bus.busy),      36'h0);
    chk({tag, "_underrun"},  36'(bus.underrun),  36'h0);
    chk({tag, "_start_err"}, 36'(bus.start_err), 36'h0);
    chk({tag, "_burst_cnt"}, 36'(bus.burst_cnt), 36'h0);
    chk({tag, "_fifo_rd"},   36'(bus.fifo_rd),   36'h0);
  endtask

  initial begin
    bus.wr_start = 1'b0;
    drive_fifo();
    repeat (2) @(posedge clk_270);
    #1;
    chk_all_zero("reset");
    wb_rst = 1'b0;

    // Full burst led by a known word for the packing check.
    push(36'hA5A5_1234_9);
    push_rand(3);
    step(1'b1);
    repeat (10) step(1'b0);

    // Only two words available: last two slots go out masked and underrun latches.
    push_rand(2);
    step(1'b1);
    repeat (10) step(1'b0);

    // Back-to-back: second start lands on the postamble edge.
    push_rand(8);
    step(1'b1);
    repeat (WL + BL) step(1'b0);
    step(1'b1);
    repeat (12) step(1'b0);

    // Start while the burst is in flight is refused and flagged.
    push_rand(4);
    step(1'b1);
    repeat (WL + 1) step(1'b0);
    step(1'b1);
    repeat (10) step(1'b0);

    repeat (400) begin
      if (fifo_q.size() < 6 && $urandom_range(0, 1) == 1) push_rand(1);
      step($urandom_range(0, 7) == 0);
    end
    repeat (12) step(1'b0);

    // Asynchronous reset in the middle of the data words.
    push_rand(4);
    step(1'b1);
    repeat (WL + 2) step(1'b0);
    #2;
    wb_rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    @(posedge clk_270);
    #1;
    cyc++;
    wb_rst = 1'b0;
    a = -100; und_m = 0; serr_m = 0; bcnt = 0;
    fifo_q.delete();
    mdl_q.delete();
    drive_fifo();

    push_rand(4);
    step(1'b1);
    repeat (10) step(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
